// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared direction codes, FSM states and heading helpers for the snake head
package snake_pkg;

   localparam logic [2:0] DIR_LEFT  = 3'd0;
   localparam logic [2:0] DIR_RIGHT = 3'd1;
   localparam logic [2:0] DIR_UP    = 3'd2;
   localparam logic [2:0] DIR_DOWN  = 3'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DEAD = 2'd2
   } snake_state_t;

   function automatic logic is_reverse(input logic [2:0] a, input logic [2:0] b);
      return (a == DIR_LEFT  && b == DIR_RIGHT) ||
             (a == DIR_RIGHT && b == DIR_LEFT)  ||
             (a == DIR_UP    && b == DIR_DOWN)  ||
             (a == DIR_DOWN  && b == DIR_UP);
   endfunction

endpackage

// File: rtl/snake_step_tick.sv
// rtl/snake_step_tick.sv - step-period counter with enable/clear; tick marks the last count
module snake_step_tick #(
   parameter int STEP_DIV = 5_000_000
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CNT_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STEP_DIV - 1);

   logic [CNT_W-1:0] cnt;

   // tick is not gated by en so the caller can qualify it without a comb loop
   assign tick = (cnt == CNT_MAX);

   always_ff @(posedge sys_clk) begin
      if (sys_rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tick ? '0 : cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/snake_head_ctrl.sv
// rtl/snake_head_ctrl.sv - snake head stepper with wall collision; SNAKE_PAUSE_EN adds a pause input
module snake_head_ctrl
   import snake_pkg::*;
#(
   parameter int GRID_W   = 32,
   parameter int GRID_H   = 24,
   parameter int X_W      = 6,
   parameter int Y_W      = 5,
   parameter int STEP_DIV = 5_000_000,
   parameter int START_X  = 16,
   parameter int START_Y  = 12
) (
   input  logic           sys_clk,
   input  logic           sys_rst,
   input  logic [2:0]     direction,
   input  logic           start,
`ifdef SNAKE_PAUSE_EN
   input  logic           pause,
`endif
   output logic [X_W-1:0] head_x,
   output logic [Y_W-1:0] head_y,
   output logic [2:0]     dsign,
   output logic           step_pulse,
   output logic           pengzhuang,
   output logic           game_over
);

   localparam logic [X_W-1:0] X_MAX   = X_W'(GRID_W - 1);
   localparam logic [Y_W-1:0] Y_MAX   = Y_W'(GRID_H - 1);
   localparam logic [X_W-1:0] X_START = X_W'(START_X);
   localparam logic [Y_W-1:0] Y_START = Y_W'(START_Y);

   snake_state_t   state_q, state_d;
   logic [X_W-1:0] head_x_d;
   logic [Y_W-1:0] head_y_d;
   logic [2:0]     dsign_d;
   logic [2:0]     heading;
   logic           step_d, peng_d, hit;
   logic           cnt_en, cnt_clr, tick, pause_active;

`ifdef SNAKE_PAUSE_EN
   assign pause_active = pause;
`else
   assign pause_active = 1'b0;
`endif

   snake_step_tick #(.STEP_DIV(STEP_DIV)) u_step_tick (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .en      (cnt_en),
      .clr     (cnt_clr),
      .tick    (tick)
   );

   always_comb begin
      state_d  = state_q;
      head_x_d = head_x;
      head_y_d = head_y;
      dsign_d  = dsign;
      step_d   = 1'b0;
      peng_d   = 1'b0;
      cnt_en   = 1'b0;
      cnt_clr  = 1'b0;
      // invalid or reversing requests fall back to the committed heading
      heading  = (!direction[2] && !is_reverse(direction, dsign)) ? direction : dsign;
      hit      = (heading == DIR_LEFT  && head_x == '0)   ||
                 (heading == DIR_RIGHT && head_x == X_MAX) ||
                 (heading == DIR_UP    && head_y == '0)   ||
                 (heading == DIR_DOWN  && head_y == Y_MAX);
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               cnt_clr = 1'b1;
            end
         end
         ST_RUN: begin
            cnt_en = !pause_active;
            if (cnt_en && tick) begin
               if (hit) begin
                  peng_d  = 1'b1;
                  state_d = ST_DEAD;
               end else begin
                  step_d  = 1'b1;
                  dsign_d = heading;
                  case (heading)
                     DIR_LEFT:  head_x_d = head_x - X_W'(1);
                     DIR_RIGHT: head_x_d = head_x + X_W'(1);
                     DIR_UP:    head_y_d = head_y - Y_W'(1);
                     default:   head_y_d = head_y + Y_W'(1);
                  endcase
               end
            end
         end
         ST_DEAD: begin
            if (start) begin
               state_d  = ST_RUN;
               cnt_clr  = 1'b1;
               head_x_d = X_START;
               head_y_d = Y_START;
               dsign_d  = DIR_LEFT;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q    <= ST_IDLE;
         head_x     <= X_START;
         head_y     <= Y_START;
         dsign      <= DIR_LEFT;
         step_pulse <= 1'b0;
         pengzhuang <= 1'b0;
      end else begin
         state_q    <= state_d;
         head_x     <= head_x_d;
         head_y     <= head_y_d;
         dsign      <= dsign_d;
         step_pulse <= step_d;
         pengzhuang <= peng_d;
      end
   end

   assign game_over = (state_q == ST_DEAD);

endmodule

// File: tb/tb_snake_head_ctrl.sv
// tb/tb_snake_head_ctrl.sv - directed self-checking bench for snake_head_ctrl on an 8x6 grid
module tb_snake_head_ctrl;

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic [2:0] direction = 3'd0;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic [2:0] head_x;
   logic [2:0] head_y;
   logic [2:0] dsign;
   logic       step_pulse, pengzhuang, game_over;

   int err_cnt = 0;
   int chk_cnt = 0;

   always #5 sys_clk = ~sys_clk;

   snake_head_ctrl #(
      .GRID_W(8), .GRID_H(6), .X_W(3), .Y_W(3),
      .STEP_DIV(4), .START_X(4), .START_Y(3)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .direction  (direction),
      .start      (start),
`ifdef SNAKE_PAUSE_EN
      .pause      (pause),
`endif
      .head_x     (head_x),
      .head_y     (head_y),
      .dsign      (dsign),
      .step_pulse (step_pulse),
      .pengzhuang (pengzhuang),
      .game_over  (game_over)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc(1);
      start = 1'b0;
   endtask

   task automatic quiet(input string tag, input int n);
      int stray = 0;
      for (int i = 0; i < n; i++) begin
         cyc(1);
         if (step_pulse || pengzhuang) stray++;
      end
      check(tag, stray, 0);
   endtask

   // three silent cycles, then the wrap edge
   task automatic do_step(input string tag, input int ex, input int ey, input int ed, input logic exp_hit);
      quiet({tag, " gap"}, 3);
      cyc(1);
      check({tag, " step_pulse"}, step_pulse, !exp_hit);
      check({tag, " pengzhuang"}, pengzhuang, exp_hit);
      check({tag, " head_x"}, head_x, ex);
      check({tag, " head_y"}, head_y, ey);
      check({tag, " dsign"}, dsign, ed);
      check({tag, " game_over"}, game_over, exp_hit);
   endtask

   task automatic check_home(input string tag);
      check({tag, " head_x"}, head_x, 4);
      check({tag, " head_y"}, head_y, 3);
      check({tag, " dsign"}, dsign, 0);
      check({tag, " game_over"}, game_over, 0);
   endtask

   initial begin
      cyc(2);
      sys_rst = 1'b0;
      check_home("reset");
      check("reset step_pulse", step_pulse, 0);
      check("reset pengzhuang", pengzhuang, 0);
      quiet("idle no step", 20);
      check_home("idle hold");

      // march left into the wall
      direction = 3'd0;
      pulse_start();
      do_step("left1", 3, 3, 0, 1'b0);
      do_step("left2", 2, 3, 0, 1'b0);
      do_step("left3", 1, 3, 0, 1'b0);
      do_step("left4", 0, 3, 0, 1'b0);
      do_step("left wall", 0, 3, 0, 1'b1);
      cyc(1);
      check("peng one cycle", pengzhuang, 0);
      check("dead game_over", game_over, 1);
      quiet("dead quiet", 8);
      check("dead head_x", head_x, 0);

      // restart, reverse rejected, turn up, invalid ignored, reverse of up rejected
      pulse_start();
      check_home("restart");
      do_step("restart first", 3, 3, 0, 1'b0);
      direction = 3'd1;
      do_step("reverse ignored", 2, 3, 0, 1'b0);
      direction = 3'd2;
      do_step("turn up", 2, 2, 2, 1'b0);
      direction = 3'd5;
      do_step("invalid ignored", 2, 1, 2, 1'b0);
      direction = 3'd3;
      do_step("down rev ignored", 2, 0, 2, 1'b0);
      direction = 3'd2;
      do_step("top wall", 2, 0, 2, 1'b1);

      // bottom wall
      pulse_start();
      direction = 3'd3;
      do_step("down1", 4, 4, 3, 1'b0);
      do_step("down2", 4, 5, 3, 1'b0);
      do_step("bottom wall", 4, 5, 3, 1'b1);

      // right wall, with a mid-step direction glitch that must be ignored
      pulse_start();
      do_step("down3", 4, 4, 3, 1'b0);
      direction = 3'd1;
      do_step("right1", 5, 4, 1, 1'b0);
      do_step("right2", 6, 4, 1, 1'b0);
      cyc(1);
      direction = 3'd2;
      cyc(1);
      direction = 3'd1;
      quiet("glitch gap", 1);
      cyc(1);
      check("glitch head_x", head_x, 7);
      check("glitch head_y", head_y, 4);
      check("glitch dsign", dsign, 1);
      do_step("right wall", 7, 4, 1, 1'b1);

      // reset mid-run at cnt==2
      direction = 3'd0;
      pulse_start();
      do_step("pre-reset", 3, 3, 0, 1'b0);
      cyc(2);
      sys_rst = 1'b1;
      cyc(1);
      sys_rst = 1'b0;
      check_home("midrun reset");
      check("midrun reset step", step_pulse, 0);
      quiet("after reset idle", 12);

      // start together with reset: reset wins
      sys_rst = 1'b1;
      start = 1'b1;
      cyc(1);
      sys_rst = 1'b0;
      start = 1'b0;
      quiet("rst+start idle", 12);
      check_home("rst+start");

`ifdef SNAKE_PAUSE_EN
      pulse_start();
      cyc(2);
      pause = 1'b1;
      quiet("paused", 10);
      pause = 1'b0;
      quiet("resume gap", 1);
      cyc(1);
      check("resume step", step_pulse, 1);
      check("resume head_x", head_x, 3);
`endif

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
